// File: rtl/wavegen_pkg.sv
// Shared sample types for the waveform generator and its I2S transmitter.
// The generator wrapper reuses the same sample and pair definitions.
package wavegen_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t a;
    sample_t b;
  } sample_pair_t;

endpackage

// File: rtl/wavegen_i2s_tx_if.sv
// Sample-pair valid/ready handshake feeding the I2S transmitter.
// The source drives a/b/valid; the transmitter answers with ready.
interface wavegen_i2s_tx_if
  import wavegen_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W
);

  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  valid;
  logic                  ready;

  modport master (
    output a, b, valid,
    input  ready
  );

  modport slave (
    input  a, b, valid,
    output ready
  );

endinterface

// File: rtl/i2s_clk_div.sv
// BCLK divider: toggles bclk every BCLK_HALF clk cycles while enabled.
// fall strobes on the cycle whose edge takes bclk from 1 to 0.
module i2s_clk_div #(
  parameter int BCLK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] LAST = DW'(BCLK_HALF - 1);

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = (div == LAST);
  assign fall = en && wrap && bclk;

  // Divider counter and bit clock; held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (wrap) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/wavegen_i2s_tx.sv
// I2S transmitter: one holding register, frame register and serializer.
// Channel A goes out on lrclk=0, channel B on lrclk=1, MSB one BCLK late.
module wavegen_i2s_tx
  import wavegen_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  wavegen_i2s_tx_if.slave   src,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun,
  input  logic              clr_underrun
);

  localparam int PW = $clog2(2 * SLOT_WIDTH);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(2 * SLOT_WIDTH - 1);
  localparam logic [PW-1:0] POS_B = PW'(SLOT_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } pair_t;

  pair_t         hold;
  pair_t         frame;
  logic          full;
  logic          fall;
  logic          start;
  logic          accept;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nxt;
  logic          lr_nxt;
  logic          sd_nxt;
  int            p;

  i2s_clk_div #(
    .BCLK_HALF(BCLK_HALF)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bclk(bclk),
    .fall(fall)
  );

  assign accept    = src.valid && !full;
  assign start     = fall && (pos == POS_LAST);
  assign src.ready = !full;

  // Next slot position and the lrclk/sdata values it selects.
  always_comb begin
    pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
    lr_nxt  = (pos_nxt >= POS_B);
    p       = int'(pos_nxt);
    sd_nxt  = 1'b0;
    if (p >= 1 && p <= DATA_WIDTH) begin
      sd_nxt = frame.a[IW'(DATA_WIDTH - p)];
    end else if (p >= SLOT_WIDTH + 1 &&
                 p <= SLOT_WIDTH + DATA_WIDTH) begin
      sd_nxt = frame.b[IW'(DATA_WIDTH + SLOT_WIDTH - p)];
    end
  end

  // Holding register fill and hand-off to the frame register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold  <= '0;
      frame <= '0;
      full  <= 1'b0;
    end else if (accept) begin
      hold <= pair_t'({src.a, src.b});
      full <= 1'b1;
    end else if (start && full) begin
      frame <= hold;
      full  <= 1'b0;
    end
  end

  // Slot position and serial outputs, updated on falling BCLK ticks.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pos   <= POS_LAST;
      lrclk <= 1'b0;
      sdata <= 1'b0;
    end else if (fall) begin
      pos   <= pos_nxt;
      lrclk <= lr_nxt;
      sdata <= sd_nxt;
    end
  end

  // Frame start pulse and sticky underrun; a set beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= start;
      if (start && !full) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wavegen_i2s_tx.sv
// Bench for wavegen_i2s_tx: time-indexed reference model plus directed
// and randomized scenarios with literal frame expectations.
module tb_wavegen_i2s_tx;

  localparam int DW = 16;
  localparam int S  = 32;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clr_underrun;
  logic bclk, lrclk, sdata, frame_start, underrun;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  wavegen_i2s_tx_if #(.DATA_WIDTH(DW)) src ();

  wavegen_i2s_tx #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(S),
    .BCLK_HALF (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .src         (src),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun),
    .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  // Reference model: m_n counts enabled clk edges since enable/reset.
  int          m_n;
  logic        m_full, m_under, m_start;
  logic [31:0] m_hold;
  logic [15:0] m_fa, m_fb;

  function automatic bit is_start(int n);
    return n > 0 && (n % (2 * H)) == 0 &&
           ((n / (2 * H) - 1) % (2 * S)) == 0;
  endfunction

  function automatic logic exp_bclk(int n);
    return ((n / H) % 2) == 1;
  endfunction

  function automatic logic exp_lr(int n);
    int f;
    f = n / (2 * H);
    if (f == 0) return 1'b0;
    return ((f - 1) % (2 * S)) >= S;
  endfunction

  function automatic logic exp_sd(int n, logic [15:0] fa,
                                  logic [15:0] fb);
    int f, p;
    f = n / (2 * H);
    if (f == 0) return 1'b0;
    p = (f - 1) % (2 * S);
    if (p >= 1 && p <= DW) return fa[4'(DW - p)];
    if (p >= S + 1 && p <= S + DW) return fb[4'(DW + S - p)];
    return 1'b0;
  endfunction

  function automatic logic [63:0] frame_vec(logic [15:0] a,
                                            logic [15:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < DW; i++) begin
      v[6'(1 + i)]  = a[4'(DW - 1 - i)];
      v[6'(33 + i)] = b[4'(DW - 1 - i)];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_n     <= 0;
      m_full  <= 1'b0;
      m_under <= 1'b0;
      m_start <= 1'b0;
      m_hold  <= '0;
      m_fa    <= '0;
      m_fb    <= '0;
    end else begin
      m_n     <= en ? m_n + 1 : 0;
      m_start <= en && is_start(m_n + 1);
      if (en && is_start(m_n + 1)) begin
        if (m_full) begin
          m_fa   <= m_hold[31:16];
          m_fb   <= m_hold[15:0];
          m_full <= 1'b0;
        end else begin
          m_under <= 1'b1;
        end
      end
      if (src.valid && !m_full) begin
        m_hold <= {src.a, src.b};
        m_full <= 1'b1;
      end
      if (clr_underrun && !(en && is_start(m_n + 1) && !m_full))
        m_under <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("bclk", 64'(bclk), 64'(exp_bclk(m_n)));
      check("lrclk", 64'(lrclk), 64'(exp_lr(m_n)));
      check("sdata", 64'(sdata), 64'(exp_sd(m_n, m_fa, m_fb)));
      check("frame_start", 64'(frame_start), 64'(m_start));
      check("in_ready", 64'(src.ready), 64'(!m_full));
      check("underrun", 64'(underrun), 64'(m_under));
    end
  end

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (frame_start !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (frame_start !== 1'b1) check("start_timeout", 64'(frame_start), 1);
  endtask

  task automatic capture(output logic [63:0] sdv,
                         output logic [63:0] lrv);
    int c;
    wait_start(c);
    sdv = '0;
    lrv = '0;
    for (int p = 0; p < 64; p++) begin
      repeat (4) @(negedge clk);
      sdv[p] = sdata;
      lrv[p] = lrclk;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] LR_VEC = 64'hFFFF_FFFF_0000_0000;

  initial begin
    logic [63:0] sd1, lr1, sd2, lr2;
    logic [15:0] pa, pb;
    int cyc, frames, accepts, k;
    bit pending;

    rst = 1'b1;
    en = 1'b1;
    clr_underrun = 1'b0;
    src.valid = 1'b1;
    src.a = 16'($urandom);
    src.b = 16'($urandom);
    @(posedge clk);
    #1 chk_on = 1'b1;

    // 1: reset with en and valid high
    repeat (3) @(negedge clk);
    check("rst_bclk", 64'(bclk), 0);
    check("rst_lrclk", 64'(lrclk), 0);
    check("rst_sdata", 64'(sdata), 0);
    check("rst_ready", 64'(src.ready), 1);
    check("rst_fs", 64'(frame_start), 0);
    check("rst_under", 64'(underrun), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_accept", 64'(src.ready), 0);
    rst = 1'b1;
    en = 1'b0;
    src.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 2: known pair, first frame
    src.a = 16'h8001;
    src.b = 16'h7FFE;
    src.valid = 1'b1;
    @(negedge clk);
    src.valid = 1'b0;
    check("held_ready", 64'(src.ready), 0);
    en = 1'b1;
    wait_start(cyc);
    check("first_start_latency", 64'(cyc), 8);
    capture(sd1, lr1);
    check("frame1_sdata", sd1, 64'h0000_FFFC_0001_0002);
    check("frame1_lrclk", lr1, LR_VEC);

    // 4: underrun repeats the frame; clear collides with set
    check("underrun_set", 64'(underrun), 1);
    capture(sd2, lr2);
    check("repeat_sdata", sd2, 64'h0000_FFFC_0001_0002);
    check("repeat_lrclk", lr2, LR_VEC);
    k = 0;
    while (m_n % 512 != 7 && k < 1100) begin
      @(negedge clk);
      k++;
    end
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("clr_on_start_fs", 64'(frame_start), 1);
    check("clr_on_start_under", 64'(underrun), 1);
    repeat (5) @(negedge clk);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("clr_later", 64'(underrun), 0);

    // 3: continuous random feed, one accept per frame
    src.a = 16'($urandom);
    src.b = 16'($urandom);
    src.valid = 1'b1;
    frames = 0;
    accepts = 0;
    pending = 1'b0;
    k = 0;
    while (frames < 4 && k < 3000) begin
      @(negedge clk);
      k++;
      if (pending) begin
        src.a = 16'($urandom);
        src.b = 16'($urandom);
        pending = 1'b0;
      end
      if (frame_start) begin
        check("ready_at_start", 64'(src.ready), 1);
        if (frames > 0) check("accepts_per_frame", 64'(accepts), 1);
        frames++;
        accepts = 0;
      end
      if (src.valid && src.ready) begin
        accepts++;
        pending = (frames < 4);
      end
    end
    check("feed_frames", 64'(frames), 4);
    check("feed_no_underrun", 64'(underrun), 0);

    // 5: disable at pos 20 with a pair held
    pa = src.a;
    pb = src.b;
    @(negedge clk);
    src.valid = 1'b0;
    repeat (165) @(negedge clk);
    check("pre_disable_bclk", 64'(bclk), 1);
    en = 1'b0;
    @(negedge clk);
    check("dis_bclk", 64'(bclk), 0);
    check("dis_lrclk", 64'(lrclk), 0);
    check("dis_sdata", 64'(sdata), 0);
    check("dis_held", 64'(src.ready), 0);
    repeat (10) @(negedge clk);
    check("dis_still_held", 64'(src.ready), 0);
    en = 1'b1;
    wait_start(cyc);
    check("reen_latency", 64'(cyc), 8);
    capture(sd1, lr1);
    check("reen_sdata", sd1, frame_vec(pa, pb));
    check("reen_lrclk", lr1, LR_VEC);

    // 6: reset at pos 40 with the holding register full
    src.a = 16'($urandom);
    src.b = 16'($urandom);
    src.valid = 1'b1;
    @(negedge clk);
    src.valid = 1'b0;
    repeat (322) @(negedge clk);
    check("pos40_lrclk", 64'(lrclk), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_lrclk", 64'(lrclk), 0);
    check("mid_rst_bclk", 64'(bclk), 0);
    check("mid_rst_sdata", 64'(sdata), 0);
    check("mid_rst_ready", 64'(src.ready), 1);
    check("mid_rst_under", 64'(underrun), 0);
    wait_start(cyc);
    check("post_rst_latency", 64'(cyc), 8);
    check("post_rst_under", 64'(underrun), 1);
    capture(sd1, lr1);
    check("post_rst_sdata", sd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wavegen_i2s_tx.md
Name: wavegen_i2s_tx

Overview:
Downstream consumer of the waveform generator's two signed sample channels (out_a, out_b). It buffers one A/B sample pair and serializes it as a standard I2S frame (A = left, B = right) for an external stereo DAC. BCLK and LRCLK are generated by dividing the system clock. The block has one holding register, a valid/ready input handshake, and a sticky underrun flag.

Parameters:
DATA_WIDTH, 16, sample width per channel (two's complement, MSB first)
SLOT_WIDTH, 32, BCLK periods per channel slot; constraint SLOT_WIDTH >= DATA_WIDTH+1
BCLK_HALF, 4, clk cycles per BCLK half-period; constraint >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  serializer enable
in_a  in  DATA_WIDTH  channel A sample (signed)
in_b  in  DATA_WIDTH  channel B sample (signed)
in_valid  in  1  sample pair valid
in_ready  out  1  holding register empty
bclk  out  1  I2S bit clock
lrclk  out  1  I2S word select (0 = A, 1 = B)
sdata  out  1  I2S serial data
frame_start  out  1  one-cycle pulse when a new frame begins
underrun  out  1  sticky: a frame started with the holding register empty
clr_underrun  in  1  clears underrun

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and rst, as decided.
- Reset values: bclk=0, lrclk=0, sdata=0, in_ready=1, frame_start=0, underrun=0. Reset also clears the holding register and frame register, clears the divider, and sets position pos=2*SLOT_WIDTH-1. Reset mid-frame aborts the frame on the next edge.
- Input handshake: capture in_a/in_b into the holding register on a cycle where in_valid && in_ready. in_ready goes to 0 on the next cycle. There is no combinational path from in_valid to in_ready.
- Divider: counter div runs 0..BCLK_HALF-1 while en=1. At div==BCLK_HALF-1, bclk toggles. A 1->0 toggle is a "falling tick".
- Position: on each falling tick, pos advances modulo 2*SLOT_WIDTH. sdata and lrclk update only on falling ticks (the DAC samples on the rising edge).
- Frame start: the falling tick that takes pos to 0.
  - If the holding register is full: load it into the frame register and clear it; in_ready=1 on the next cycle.
  - If the holding register is empty: reuse the previous frame register contents and set underrun.
  - In both cases, frame_start=1 for exactly one cycle.
- Output mapping at position p:
  - lrclk = 1 when p in [SLOT_WIDTH, 2*SLOT_WIDTH-1], else 0.
  - sdata = A[DATA_WIDTH-p] for p in 1..DATA_WIDTH.
  - sdata = B[DATA_WIDTH-(p-SLOT_WIDTH)] for p in SLOT_WIDTH+1..SLOT_WIDTH+DATA_WIDTH.
  - sdata = 0 otherwise.
  - Result: the MSB of each channel lags the lrclk edge by one BCLK.
- Timing: frame period = 4*SLOT_WIDTH*BCLK_HALF clk cycles (512 at defaults). From en rising, the first falling tick (frame start) occurs 2*BCLK_HALF cycles later.
- en=0, effective the next cycle: div=0, bclk=0, lrclk=0, sdata=0, pos=2*SLOT_WIDTH-1. The holding register and handshake keep operating. Mid-frame disable discards the partial frame.
- Underrun flag: clr_underrun clears it. If a set and a clear occur in the same cycle, set wins.
- No arithmetic on samples. Bits are passed through exactly; sign is preserved by MSB-first transmission.

Decomposition:
- Shared package wavegen_pkg:
  - SAMPLE_W=16 constant
  - typedef sample_t (signed [SAMPLE_W-1:0])
  - typedef struct sample_pair_t {a, b}
  - both reused by the generator wrapper
- Sub-module i2s_clk_div:
  - divider counter plus bclk register
  - emits a falling-tick strobe
  - resets on rst or !en
- Position counter, holding/frame registers and output mux stay in the top module.

Test Plan:
1. Assert rst for 3 cycles with en=1 and in_valid=1 -> all outputs at reset values; in_ready=1 on the first cycle after rst falls.
2. Load A=16'h8001, B=16'h7FFE, then en=1 -> bclk period 8 clk cycles; frame_start at cycle 8. lrclk low for 32 BCLK, then high for 32. sdata positions 1..16 = 1000_0000_0000_0001, positions 17..31 = 0, positions 33..48 = 0111_1111_1111_1110.
3. Hold in_valid=1 with incrementing pairs -> exactly one accept per 512 cycles. in_ready is high for one cycle after each frame_start. No underrun; transmitted pairs are in order.
4. Send one pair, then stop -> the second frame repeats the same bits and underrun=1 at frame_start+1. Pulse clr_underrun on the next underrun frame_start -> underrun stays 1. Pulse it later -> underrun 0.
5. Deassert en at pos 20 -> bclk/lrclk/sdata are 0 the next cycle and the held pair is retained. Re-enable -> frame_start after 8 cycles, and the new frame carries the held pair.
6. Assert rst at pos 40 with the holding register full -> outputs reset the next cycle; the held pair is discarded; underrun=0.
